// File: rtl/dds_ram_pkg.sv
// Shared types and default widths for the RAM_DDS waveform RAM arbiter.
// Grant and in-flight read tag encodings plus the dropped-tick counter width.
package dds_ram_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 10;
  localparam int PHASE_W_DEF  = 32;
  localparam int STARVE_DEF   = 4;
  localparam int DROP_CNT_W   = 16;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PLAY,
    GNT_HOST_WR,
    GNT_HOST_RD
  } gnt_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_PLAY,
    TAG_HOST_RD
  } tag_t;

endpackage

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with clear, advance and offset address extraction.
// Ports: clk, rst, adv_i (tick honoured), clr_i, ftw_i, pow_i -> addr_o.
module dds_phase_acc #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adv_i,
  input  logic                   clr_i,
  input  logic [PHASE_WIDTH-1:0] ftw_i,
  input  logic [ADDR_WIDTH-1:0]  pow_i,
  output logic [ADDR_WIDTH-1:0]  addr_o
);

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr_i)
      phase_d = '0;
    else if (adv_i)
      phase_d = phase_q + ftw_i;
  end

  always_ff @(posedge clk) begin
    if (rst)
      phase_q <= '0;
    else
      phase_q <= phase_d;
  end

  // Address always comes from the pre-update phase.
  assign addr_o = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + pow_i;

endmodule

// File: rtl/dds_ram_arbiter.sv
// Single-port waveform RAM sequencer: DDS playback vs host load/readback.
// Ports: clk/rst; en,tick,phase_clr,ftw,pow; h_* host; sample*; drop_cnt; ram_*.
module dds_ram_arbiter
  import dds_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int PHASE_WIDTH  = PHASE_W_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF,
  parameter int DROP_WIDTH   = DROP_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   tick,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic [ADDR_WIDTH-1:0]  pow,
  input  logic                   h_valid,
  input  logic                   h_we,
  input  logic [ADDR_WIDTH-1:0]  h_addr,
  input  logic [DATA_WIDTH-1:0]  h_wdata,
  output logic                   h_ready,
  output logic                   h_rvalid,
  output logic [DATA_WIDTH-1:0]  h_rdata,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic [DROP_WIDTH-1:0]  drop_cnt,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   ram_wrn,
  input  logic [DATA_WIDTH-1:0]  ram_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic play_req, starved, drop;
  logic host_force, host_norm, host_gnt, play_win;
  gnt_t gnt;
  tag_t tag_q, tag_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] play_addr, ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_din_q, sample_q, h_rdata_q;
  logic                  sample_valid_q, h_rvalid_q;

  dds_phase_acc #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .adv_i (play_req),
    .clr_i (phase_clr),
    .ftw_i (ftw),
    .pow_i (pow),
    .addr_o(play_addr)
  );

  assign play_req = en & tick;
  assign starved  = (starve_q >= STARVE_MAX);

  // Mutually exclusive grant terms; nothing is granted during reset.
  assign host_force = !rst & starved & h_valid;
  assign play_win   = !rst & play_req & !host_force;
  assign host_norm  = !rst & h_valid & !play_req & !starved;
  assign host_gnt   = host_force | host_norm;
  assign drop       = host_force & play_req;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      host_gnt: gnt = h_we ? GNT_HOST_WR : GNT_HOST_RD;
      play_win: gnt = GNT_PLAY;
      default:  gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    ram_addr = ram_addr_q;
    ram_din  = ram_din_q;
    ram_wrn  = 1'b0;
    h_ready  = 1'b0;
    tag_d    = TAG_NONE;
    unique case (gnt)
      GNT_PLAY: begin
        ram_addr = play_addr;
        tag_d    = TAG_PLAY;
      end
      GNT_HOST_WR: begin
        ram_addr = h_addr;
        ram_din  = h_wdata;
        ram_wrn  = 1'b1;
        h_ready  = 1'b1;
      end
      GNT_HOST_RD: begin
        ram_addr = h_addr;
        h_ready  = 1'b1;
        tag_d    = TAG_HOST_RD;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (host_gnt || !h_valid)
      starve_d = '0;
    else if (play_win && !starved)
      starve_d = starve_q + 1'b1;
  end

  assign drop_d = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q          <= TAG_NONE;
      starve_q       <= '0;
      drop_q         <= '0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      sample_q       <= '0;
      h_rdata_q      <= '0;
      sample_valid_q <= 1'b0;
      h_rvalid_q     <= 1'b0;
    end else begin
      tag_q          <= tag_d;
      starve_q       <= starve_d;
      drop_q         <= drop_d;
      ram_addr_q     <= ram_addr;
      ram_din_q      <= ram_din;
      sample_valid_q <= (tag_q == TAG_PLAY);
      h_rvalid_q     <= (tag_q == TAG_HOST_RD);
      if (tag_q == TAG_PLAY)
        sample_q <= ram_dout;
      if (tag_q == TAG_HOST_RD)
        h_rdata_q <= ram_dout;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign h_rdata      = h_rdata_q;
  assign h_rvalid     = h_rvalid_q;
  assign drop_cnt     = drop_q;

endmodule
